// File: rtl/ev_ctrl_pkg.sv
// Shared types and defaults for the EV speed command path.
package ev_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAMP_UP = 3'd1,
    RAMP_DN = 3'd2,
    HOLD    = 3'd3,
    ESTOP   = 3'd4
  } ev_state_t;

  localparam logic SRC_PLC = 1'b0;
  localparam logic SRC_HMI = 1'b1;

  localparam int DEF_RAMP_DIV  = 16;
  localparam int DEF_STEP      = 4;
  localparam int DEF_MAX_SPEED = 240;

  function automatic logic [7:0] clamp_target(input logic [7:0] t, input logic [7:0] max_t);
    return (t > max_t) ? max_t : t;
  endfunction

endpackage

// File: rtl/ev_ramp_gen.sv
// Rate-limited setpoint generator: moves speed_sp toward eff by at most STEP per tick.
module ev_ramp_gen
  import ev_ctrl_pkg::*;
#(
  parameter int RAMP_DIV = DEF_RAMP_DIV,
  parameter int STEP     = DEF_STEP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] eff,
  output logic [7:0] speed_sp
);

  localparam int CW = $clog2(RAMP_DIV);

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [7:0]    diff;
  logic [7:0]    step_amt;

  assign tick = (tick_cnt == CW'(RAMP_DIV - 1));

  // Step is limited to the remaining distance, so the setpoint never overshoots.
  always_comb begin
    diff     = (speed_sp < eff) ? (eff - speed_sp) : (speed_sp - eff);
    step_amt = (diff > 8'(STEP)) ? 8'(STEP) : diff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      speed_sp <= '0;
    end else if (clear) begin
      tick_cnt <= '0;
      speed_sp <= '0;
    end else if (enable) begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        speed_sp <= (speed_sp < eff) ? (speed_sp + step_amt) : (speed_sp - step_amt);
      end
    end
  end

endmodule

// File: rtl/ev_speed_sequencer.sv
// PLC/HMI speed-command arbiter with ramped setpoint, thermal derate and power-loss stop.
module ev_speed_sequencer
  import ev_ctrl_pkg::*;
#(
  parameter int RAMP_DIV  = DEF_RAMP_DIV,
  parameter int STEP      = DEF_STEP,
  parameter int MAX_SPEED = DEF_MAX_SPEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_en,
  input  logic       mode_sel,
  input  logic       mode_lock,
  input  logic       plc_req,
  input  logic [7:0] plc_target,
  input  logic       hmi_req,
  input  logic [7:0] hmi_target,
  input  logic       thermal_fault,
  output logic       plc_gnt,
  output logic       hmi_gnt,
  output logic       plc_nak,
  output logic       hmi_nak,
  output logic [7:0] speed_sp,
  output logic [7:0] target_q,
  output logic [2:0] state,
  output logic       at_target,
  output logic       derate,
  output logic       last_owner
);

  ev_state_t  state_q;
  logic [7:0] eff;
  logic       grant_plc, grant_hmi, nak_plc, nak_hmi;
  logic       plc_elig, hmi_elig;

  assign state = state_q;
  assign eff   = thermal_fault ? {1'b0, target_q[7:1]} : target_q;

  assign plc_elig = plc_req & ~plc_gnt;
  assign hmi_elig = hmi_req & ~hmi_gnt;

  always_comb begin
    grant_plc = 1'b0;
    grant_hmi = 1'b0;
    nak_plc   = 1'b0;
    nak_hmi   = 1'b0;
    if (power_en && state_q != ESTOP) begin
      if (mode_lock) begin
        if (mode_sel == SRC_HMI) begin
          grant_hmi = hmi_elig;
          nak_plc   = plc_req & ~plc_nak;
        end else begin
          grant_plc = plc_elig;
          nak_hmi   = hmi_req & ~hmi_nak;
        end
      end else if (plc_elig && hmi_elig) begin
        // Tie goes to whichever source did not win last time.
        grant_hmi = (last_owner == SRC_PLC);
        grant_plc = (last_owner == SRC_HMI);
      end else begin
        grant_plc = plc_elig;
        grant_hmi = hmi_elig;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      target_q   <= '0;
      plc_gnt    <= 1'b0;
      hmi_gnt    <= 1'b0;
      plc_nak    <= 1'b0;
      hmi_nak    <= 1'b0;
      at_target  <= 1'b0;
      derate     <= 1'b0;
      last_owner <= SRC_PLC;
    end else if (!power_en) begin
      state_q   <= ESTOP;
      target_q  <= '0;
      plc_gnt   <= 1'b0;
      hmi_gnt   <= 1'b0;
      plc_nak   <= 1'b0;
      hmi_nak   <= 1'b0;
      at_target <= 1'b0;
      derate    <= 1'b0;
    end else begin
      plc_gnt   <= grant_plc;
      hmi_gnt   <= grant_hmi;
      plc_nak   <= nak_plc;
      hmi_nak   <= nak_hmi;
      derate    <= thermal_fault;
      at_target <= (speed_sp == eff);
      if (grant_plc) begin
        target_q   <= clamp_target(plc_target, 8'(MAX_SPEED));
        last_owner <= SRC_PLC;
      end else if (grant_hmi) begin
        target_q   <= clamp_target(hmi_target, 8'(MAX_SPEED));
        last_owner <= SRC_HMI;
      end
      if (state_q == ESTOP)    state_q <= IDLE;
      else if (speed_sp < eff) state_q <= RAMP_UP;
      else if (speed_sp > eff) state_q <= RAMP_DN;
      else if (eff != 8'd0)    state_q <= HOLD;
      else                     state_q <= IDLE;
    end
  end

  ev_ramp_gen #(
    .RAMP_DIV(RAMP_DIV),
    .STEP    (STEP)
  ) u_ramp (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!power_en),
    .enable  (state_q != ESTOP),
    .eff     (eff),
    .speed_sp(speed_sp)
  );

endmodule

// File: tb/tb_ev_speed_sequencer.sv
// Scoreboard bench for ev_speed_sequencer: a cycle model pushes expectations, DUT outputs are popped and compared.
module tb_ev_speed_sequencer;

  localparam int RDIV  = 4;
  localparam int STEPV = 4;
  localparam int MAXS  = 240;

  logic       clk, rst_n, power_en, mode_sel, mode_lock;
  logic       plc_req, hmi_req, thermal_fault;
  logic [7:0] plc_target, hmi_target;
  logic       plc_gnt, hmi_gnt, plc_nak, hmi_nak;
  logic [7:0] speed_sp, target_q;
  logic [2:0] state;
  logic       at_target, derate, last_owner;

  ev_speed_sequencer #(.RAMP_DIV(RDIV), .STEP(STEPV), .MAX_SPEED(MAXS)) dut (
    .clk(clk), .rst_n(rst_n), .power_en(power_en), .mode_sel(mode_sel),
    .mode_lock(mode_lock), .plc_req(plc_req), .plc_target(plc_target),
    .hmi_req(hmi_req), .hmi_target(hmi_target), .thermal_fault(thermal_fault),
    .plc_gnt(plc_gnt), .hmi_gnt(hmi_gnt), .plc_nak(plc_nak), .hmi_nak(hmi_nak),
    .speed_sp(speed_sp), .target_q(target_q), .state(state),
    .at_target(at_target), .derate(derate), .last_owner(last_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sp;
    logic [7:0] tq;
    logic [2:0] st;
    logic       at;
    logic       der;
    logic       own;
    logic [3:0] pulses;  // {plc_gnt, hmi_gnt, plc_nak, hmi_nak}
  } exp_t;

  exp_t m;
  int   m_cnt;
  exp_t sb[$];
  int   n_tests;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, using the inputs currently applied.
  task automatic model_step();
    exp_t n;
    int   eff, d;
    bit   pg, hg, pn, hn, gp, gh, np, nh, pe, he;
    n = m;
    n.pulses = '0;
    eff = thermal_fault ? int'(m.tq) / 2 : int'(m.tq);
    if (!power_en) begin
      n.sp = 0; n.tq = 0; n.st = 3'd4; n.at = 0; n.der = 0;
      m_cnt = 0;
    end else if (m.st == 3'd4) begin
      n.st  = 3'd0;
      n.at  = (int'(m.sp) == eff);
      n.der = thermal_fault;
    end else begin
      {pg, hg, pn, hn} = m.pulses;
      pe = plc_req && !pg;
      he = hmi_req && !hg;
      gp = 0; gh = 0; np = 0; nh = 0;
      if (mode_lock) begin
        if (mode_sel) begin gh = he; np = plc_req && !pn; end
        else          begin gp = pe; nh = hmi_req && !hn; end
      end else if (pe && he) begin
        if (m.own) gp = 1; else gh = 1;
      end else begin
        gp = pe; gh = he;
      end
      n.pulses = {gp, gh, np, nh};
      if (gp) n.tq = (int'(plc_target) > MAXS) ? 8'(MAXS) : plc_target;
      if (gh) n.tq = (int'(hmi_target) > MAXS) ? 8'(MAXS) : hmi_target;
      if (gp || gh) n.own = gh;
      if (m_cnt == RDIV - 1) begin
        m_cnt = 0;
        d = eff - int'(m.sp);
        if (d > STEPV)  d = STEPV;
        if (d < -STEPV) d = -STEPV;
        n.sp = 8'(int'(m.sp) + d);
      end else begin
        m_cnt++;
      end
      if (int'(m.sp) < eff)      n.st = 3'd1;
      else if (int'(m.sp) > eff) n.st = 3'd2;
      else if (eff != 0)         n.st = 3'd3;
      else                       n.st = 3'd0;
      n.at  = (int'(m.sp) == eff);
      n.der = thermal_fault;
    end
    m = n;
    sb.push_back(n);
  endtask

  task automatic cyc();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("speed_sp", speed_sp, e.sp);
    chk("target_q", target_q, e.tq);
    chk("state", state, e.st);
    chk("at_target", at_target, e.at);
    chk("derate", derate, e.der);
    chk("last_owner", last_owner, e.own);
    chk("gnt_nak", {plc_gnt, hmi_gnt, plc_nak, hmi_nak}, e.pulses);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic grant_plc(input logic [7:0] t);
    plc_target = t;
    plc_req    = 1'b1;
    cyc();
    chk("plc_gnt_pulse", plc_gnt, 1);
    plc_req = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sp"}, speed_sp, 0);
    chk({tag, "_tq"}, target_q, 0);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_pulses"}, {plc_gnt, hmi_gnt, plc_nak, hmi_nak, at_target, derate, last_owner}, 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    m = '0; m_cnt = 0;
    rst_n = 1'b0; power_en = 1'b1; mode_sel = 1'b0; mode_lock = 1'b0;
    plc_req = 1'b0; hmi_req = 1'b0; thermal_fault = 1'b0;
    plc_target = 8'd0; hmi_target = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    run(2);

    // Basic ramp up to 10 then hold
    grant_plc(8'd10);
    chk("t1_tq", target_q, 10);
    run(16);
    chk("t1_sp", speed_sp, 10);
    chk("t1_state", state, 3);
    chk("t1_at", at_target, 1);

    // Async reset while ramping
    grant_plc(8'd100);
    run(10);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    m = '0; m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run(2);

    // Simultaneous requests: HMI wins the first tie, PLC follows
    plc_target = 8'd30; hmi_target = 8'd60;
    plc_req = 1'b1; hmi_req = 1'b1;
    cyc();
    chk("t2_hmi_first", {plc_gnt, hmi_gnt}, 2'b01);
    chk("t2_owner", last_owner, 1);
    hmi_req = 1'b0;
    cyc();
    chk("t2_plc_next", {plc_gnt, hmi_gnt}, 2'b10);
    plc_req = 1'b0;
    run(30);

    // Locked to HMI: PLC is refused
    mode_lock = 1'b1; mode_sel = 1'b1;
    plc_target = 8'd50; plc_req = 1'b1;
    cyc();
    chk("t3_nak", {plc_gnt, plc_nak}, 2'b01);
    chk("t3_tq_kept", target_q, 30);
    plc_req = 1'b0;
    hmi_target = 8'd50; hmi_req = 1'b1;
    cyc();
    chk("t3_hmi_gnt", hmi_gnt, 1);
    chk("t3_tq", target_q, 50);
    hmi_req = 1'b0; mode_lock = 1'b0; mode_sel = 1'b0;
    run(4);

    // Thermal derate from 200 to 100 and back
    grant_plc(8'd200);
    run(220);
    chk("t4_sp200", speed_sp, 200);
    chk("t4_hold", state, 3);
    thermal_fault = 1'b1;
    cyc();
    chk("t4_derate", derate, 1);
    chk("t4_rampdn", state, 2);
    run(120);
    chk("t4_sp100", speed_sp, 100);
    chk("t4_hold100", state, 3);
    thermal_fault = 1'b0;
    run(120);
    chk("t4_back200", speed_sp, 200);

    // Target 0 ramps down to idle
    grant_plc(8'd0);
    run(220);
    chk("t6_sp0", speed_sp, 0);
    chk("t6_idle", state, 0);

    // Power loss mid-ramp
    grant_plc(8'd100);
    run(40);
    power_en = 1'b0;
    cyc();
    chk("t5_sp0", speed_sp, 0);
    chk("t5_estop", state, 4);
    plc_req = 1'b1; hmi_req = 1'b1; hmi_target = 8'd77;
    run(3);
    chk("t5_no_pulse", {plc_gnt, hmi_gnt, plc_nak, hmi_nak}, 0);
    power_en = 1'b1;
    cyc();
    chk("t5_idle", state, 0);
    chk("t5_no_gnt_exit", {plc_gnt, hmi_gnt}, 0);
    cyc();
    chk("t5_resume_gnt", {plc_gnt, hmi_gnt}, 2'b01);
    chk("t5_tq", target_q, 77);
    plc_req = 1'b0; hmi_req = 1'b0;
    run(4);

    // Over-range target is clamped
    grant_plc(8'd255);
    chk("t6_clamp", target_q, 240);
    run(270);
    chk("t6_sp240", speed_sp, 240);
    chk("t6_hold240", state, 3);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      plc_req       = 1'($urandom_range(0, 1));
      hmi_req       = 1'($urandom_range(0, 1));
      plc_target    = 8'($urandom_range(0, 255));
      hmi_target    = 8'($urandom_range(0, 255));
      mode_lock     = ($urandom_range(0, 3) == 0);
      mode_sel      = 1'($urandom_range(0, 1));
      power_en      = ($urandom_range(0, 24) != 0);
      thermal_fault = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
